mux_scan_bmsce: RTL and testbench

Parametrised, registered N-channel multiplexer with manual and auto-scan select modes. It generalises the team's single-bit 2:1 selector to NCH channels of WIDTH bits and registers both the select and the output. It adds an automatic round-robin scan mode with a programmable dwell time, plus a valid flag and select-error reporting. It sits behind the top-level pin wrapper: channel data arrives from `ui_in`/`uio_in` slices, and `y` drives `uo_out`.

---
 rtl/mux_scan_bmsce_if.sv | 29 ++
 rtl/mux_scan_bmsce.sv | 81 ++++++++
 tb/tb_mux_scan_bmsce.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_bmsce_if.sv
// Bus bundle for mux_scan_bmsce: channel data, select controls and registered outputs.
interface mux_scan_bmsce_if #(
  parameter int WIDTH = 1,
  parameter int NCH   = 4
);
  localparam int SW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;

  logic                 ena;
  logic [NCH*WIDTH-1:0] din;
  logic [SW-1:0]        sel_in;
  logic                 sel_load;
  logic                 mode;
  logic [WIDTH-1:0]     y;
  logic [SW-1:0]        cur_sel;
  logic                 y_valid;
  logic                 sel_err;

  // Driver side: supplies data and select controls, observes results.
  modport master (
    output ena, din, sel_in, sel_load, mode,
    input  y, cur_sel, y_valid, sel_err
  );

  // Multiplexer side.
  modport slave (
    input  ena, din, sel_in, sel_load, mode,
    output y, cur_sel, y_valid, sel_err
  );
endinterface

// File: rtl/mux_scan_bmsce.sv
// Registered NCH-channel multiplexer with manual select and round-robin auto-scan.
// The select, dwell counter and all outputs are registered; ena freezes everything.
module mux_scan_bmsce #(
  parameter int WIDTH = 1,
  parameter int NCH   = 4,
  parameter int DWELL = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux_scan_bmsce_if.slave  bus
);
  localparam int SW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(DWELL);

  typedef enum logic { ST_MANUAL = 1'b0, ST_SCAN = 1'b1 } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    cur_sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             sel_err;

  logic [SW-1:0]    nxt_sel;
  logic [CW-1:0]    nxt_cnt;
  logic             nxt_err;
  logic [SW-1:0]    inc_sel;

  // Round-robin successor of the current channel, wrapping at NCH rather than 2^SW.
  assign inc_sel = (cur_sel == SW'(NCH - 1)) ? '0 : cur_sel + 1'b1;

  // Next select, dwell count and error flag for the current mode and strobes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    nxt_sel = cur_sel;
    nxt_cnt = '0;
    nxt_err = sel_err;
    if (bus.mode) begin
      // The first SCAN edge after MANUAL only clears the counter; sel_load is ignored.
      if (state == ST_SCAN) begin
        if (cnt == CW'(DWELL - 1)) begin
          nxt_sel = inc_sel;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
    end else if (bus.sel_load) begin
      if (int'(bus.sel_in) < NCH) begin
        nxt_sel = bus.sel_in;
        nxt_err = 1'b0;
      end else begin
        nxt_err = 1'b1;
      end
    end
  end

  // Register state, select, counter and outputs on each enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_MANUAL;
      cnt     <= '0;
      cur_sel <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      sel_err <= 1'b0;
    end else if (bus.ena) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values (y uses the old cur_sel).
      state   <= bus.mode ? ST_SCAN : ST_MANUAL;
      cnt     <= nxt_cnt;
      cur_sel <= nxt_sel;
      y       <= bus.din[int'(cur_sel)*WIDTH +: WIDTH];
      y_valid <= (nxt_sel == cur_sel);
      sel_err <= nxt_err;
    end
  end

  assign bus.y       = y;
  assign bus.cur_sel = cur_sel;
  assign bus.y_valid = y_valid;
  assign bus.sel_err = sel_err;
endmodule

// File: tb/tb_mux_scan_bmsce.sv
// Self-checking bench for mux_scan_bmsce with NCH=3, WIDTH=4, DWELL=4.
module tb_mux_scan_bmsce;
  localparam int W  = 4;
  localparam int N  = 3;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mux_scan_bmsce_if #(.WIDTH(W), .NCH(N)) bus ();

  mux_scan_bmsce #(.WIDTH(W), .NCH(N), .DWELL(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: channel index, position within the dwell, error flag, last output.
  int m_sel, m_pos, m_err, m_valid, m_y, m_scan;

  task automatic model_reset();
    m_sel = 0; m_pos = 0; m_err = 0; m_valid = 0; m_y = 0; m_scan = 0;
  endtask

  task automatic model_step(input logic e, m, l, input logic [1:0] s, input logic [11:0] d);
    int old;
    if (!e) return;
    old = m_sel;
    m_y = int'((d >> (old * W)) & 12'hf);
    if (m) begin
      if (!m_scan) m_pos = 0;
      else begin
        m_pos = m_pos + 1;
        if (m_pos == DW) begin
          m_pos = 0;
          m_sel = (m_sel + 1) % N;
        end
      end
    end else begin
      m_pos = 0;
      if (l) begin
        if (int'(s) < N) begin m_sel = int'(s); m_err = 0; end
        else m_err = 1;
      end
    end
    m_scan  = int'(m);
    m_valid = (m_sel == old) ? 1 : 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".y"},       int'(bus.y),       m_y);
    check({tag, ".cur_sel"}, int'(bus.cur_sel), m_sel);
    check({tag, ".y_valid"}, int'(bus.y_valid), m_valid);
    check({tag, ".sel_err"}, int'(bus.sel_err), m_err);
  endtask

  // Drive inputs between edges, take one edge, advance the model, settle.
  task automatic cycle(input logic e, m, l, input logic [1:0] s, input logic [11:0] d);
    bus.ena = e; bus.mode = m; bus.sel_load = l; bus.sel_in = s; bus.din = d;
    @(posedge clk);
    model_step(e, m, l, s, d);
    #1;
  endtask

  typedef struct {
    logic        e, m, l;
    logic [1:0]  s;
    logic [11:0] d;
    logic [3:0]  y;
    logic [1:0]  sel;
    logic        v, err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic mode_r;
    int   exp_sel, exp_v;

    // Manual-mode vectors with hand-derived expectations (ch0=[3:0], ch1=[7:4], ch2=[11:8]).
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 12'h001, 4'h1, 2'd0, 1'b1, 1'b0}; // first edge after reset
    tbl[1] = '{1'b1, 1'b0, 1'b1, 2'd2, 12'h100, 4'h0, 2'd2, 1'b0, 1'b0}; // load 2, y from old ch0
    tbl[2] = '{1'b1, 1'b0, 1'b0, 2'd0, 12'h100, 4'h1, 2'd2, 1'b1, 1'b0}; // y shows ch2
    tbl[3] = '{1'b1, 1'b0, 1'b0, 2'd0, 12'h000, 4'h0, 2'd2, 1'b1, 1'b0}; // data follows din
    tbl[4] = '{1'b1, 1'b0, 1'b1, 2'd3, 12'h000, 4'h0, 2'd2, 1'b1, 1'b1}; // out-of-range load
    tbl[5] = '{1'b1, 1'b0, 1'b0, 2'd0, 12'h000, 4'h0, 2'd2, 1'b1, 1'b1}; // error sticks
    tbl[6] = '{1'b1, 1'b0, 1'b1, 2'd1, 12'h050, 4'h0, 2'd1, 1'b0, 1'b0}; // valid load clears error
    tbl[7] = '{1'b1, 1'b0, 1'b1, 2'd1, 12'h050, 4'h5, 2'd1, 1'b1, 1'b0}; // same value: no change
    tbl[8] = '{1'b0, 1'b0, 1'b1, 2'd0, 12'h0a0, 4'h5, 2'd1, 1'b1, 1'b0}; // ena=0 drops load
    tbl[9] = '{1'b1, 1'b0, 1'b0, 2'd0, 12'h0a0, 4'ha, 2'd1, 1'b1, 1'b0}; // resumes

    bus.ena = 1'b0; bus.mode = 1'b0; bus.sel_load = 1'b0; bus.sel_in = '0; bus.din = '0;
    model_reset();
    #2;
    check("rst.y", int'(bus.y), 0);
    check("rst.cur_sel", int'(bus.cur_sel), 0);
    check("rst.y_valid", int'(bus.y_valid), 0);
    check("rst.sel_err", int'(bus.sel_err), 0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].e, tbl[i].m, tbl[i].l, tbl[i].s, tbl[i].d);
      check($sformatf("tbl%0d.y", i),       int'(bus.y),       int'(tbl[i].y));
      check($sformatf("tbl%0d.cur_sel", i), int'(bus.cur_sel), int'(tbl[i].sel));
      check($sformatf("tbl%0d.y_valid", i), int'(bus.y_valid), int'(tbl[i].v));
      check($sformatf("tbl%0d.sel_err", i), int'(bus.sel_err), int'(tbl[i].err));
    end

    // Back to channel 0, then scan: 0,0,0,0,1,1,1,1,2,2,2,2,0 with a drop after each change.
    cycle(1'b1, 1'b0, 1'b1, 2'd0, 12'h321);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 12'h321);
    check("pre_scan.cur_sel", int'(bus.cur_sel), 0);
    for (int i = 0; i < 22; i++) begin
      cycle(1'b1, 1'b1, (i == 2), 2'd3, 12'h321);
      exp_sel = (i / DW) % N;
      exp_v   = (i > 0 && i % DW == 0) ? 0 : 1;
      check($sformatf("scan%0d.cur_sel", i), int'(bus.cur_sel), exp_sel);
      check($sformatf("scan%0d.y_valid", i), int'(bus.y_valid), exp_v);
      check($sformatf("scan%0d.sel_err", i), int'(bus.sel_err), 0);
      if (i == 14) begin
        // Five disabled cycles mid-dwell: nothing moves, sequence must resume exactly.
        for (int k = 0; k < 5; k++) begin
          cycle(1'b0, 1'b1, 1'b1, 2'd1, 12'hfff);
          check($sformatf("freeze%0d.cur_sel", k), int'(bus.cur_sel), exp_sel);
          check($sformatf("freeze%0d.y", k), int'(bus.y), (exp_sel + 1) % 16);
        end
      end
    end
    // Leave scan while on channel 2: select freezes, manual loads work again.
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 12'h321);
    check("scan_exit.cur_sel", int'(bus.cur_sel), 2);
    check("scan_exit.y_valid", int'(bus.y_valid), 1);
    cycle(1'b1, 1'b0, 1'b1, 2'd0, 12'h321);
    check("scan_exit_load.cur_sel", int'(bus.cur_sel), 0);
    check("scan_exit_load.y_valid", int'(bus.y_valid), 0);
    check_model("after_directed");

    // Async reset in the middle of a dwell.
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 12'h777);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 12'h777);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 12'h777);
    #3 rst_n = 1'b0;
    #1;
    check("async.y", int'(bus.y), 0);
    check("async.cur_sel", int'(bus.cur_sel), 0);
    check("async.y_valid", int'(bus.y_valid), 0);
    check("async.sel_err", int'(bus.sel_err), 0);
    #1 rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 12'h9a6);
    check("post_rst.y", int'(bus.y), 6);
    check("post_rst.cur_sel", int'(bus.cur_sel), 0);
    check("post_rst.y_valid", int'(bus.y_valid), 1);
    cycle(1'b1, 1'b0, 1'b1, 2'd1, 12'h9a6);
    check("post_rst_manual.cur_sel", int'(bus.cur_sel), 1);
    check_model("post_rst");

    // Randomized traffic against the reference model.
    mode_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) mode_r = ~mode_r;
      cycle(($urandom_range(0, 9) != 0), mode_r, ($urandom_range(0, 2) == 0),
            2'($urandom_range(0, 3)), 12'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
